// File: rtl/i2c_pkg.sv
// Shared types for the 16-bit-address I2C target.
// State encoding, bus ACK/NACK levels, R/W bit index.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ID,
    DEV_ACK,
    ADDR_H,
    ACK_H,
    ADDR_L,
    ACK_L,
    WDATA,
    WACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_bus_sampler.sv
// SCL/SDA front end: 2-FF sync, stability filter, edge/START/STOP detect.
// Ports: clk, rst_n, scl, sda in; scl_rise, scl_fall, start_det, stop_det, sda_q out.
module i2c_bus_sampler #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_q
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 2'b11;
      s2   <= 2'b11;
      filt <= 2'b11;
      prev <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= {sda, scl};
      s2   <= s1;
      prev <= filt;
      // a new level is taken only after FILTER_LEN consecutive samples
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise  = filt[0] & ~prev[0];
  assign scl_fall  = ~filt[0] & prev[0];
  assign start_det = filt[0] & prev[0] & prev[1] & ~filt[1];
  assign stop_det  = filt[0] & prev[0] & ~prev[1] & filt[1];
  assign sda_q     = filt[1];

endmodule

// File: rtl/i2c_slave_ctrl_16bit.sv
// I2C/SCCB target, 16-bit register address, 8-bit data, auto-increment.
// Ports: bus (i2c_sclk, i2c_sdat_IN/OUT/OE), register port (reg_*), busy.
import i2c_pkg::*;

module i2c_slave_ctrl_16bit #(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_sclk,
  input  logic        i2c_sdat_IN,
  output logic        i2c_sdat_OUT,
  output logic        i2c_sdat_OE,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_q;

  i2c_bus_sampler #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (i2c_sclk),
    .sda      (i2c_sdat_IN),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_q    (sda_q)
  );

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  addr_hi;
  logic        rw;
  logic        rd_d;
  logic        oe;
  logic [7:0]  nxt;
  logic        rx_state;
  logic        last;

  assign nxt  = {shreg[6:0], sda_q};
  assign last = (bit_cnt == 4'd7);
  assign rx_state = (state == DEV_ID) || (state == ADDR_H) ||
                    (state == ADDR_L) || (state == WDATA);

  assign i2c_sdat_OUT = 1'b0;
  assign i2c_sdat_OE  = oe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr_hi   <= '0;
      rw        <= 1'b0;
      rd_d      <= 1'b0;
      oe        <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_d   <= reg_rd;
      if (reg_wr) reg_addr <= reg_addr + 16'd1;
      // read data arrives one clk after the strobe
      if (rd_d) begin
        shreg    <= reg_rdata;
        reg_addr <= reg_addr + 16'd1;
      end

      if (stop_det) begin
        state <= IDLE;
        oe    <= 1'b0;
        busy  <= 1'b0;
      end else if (start_det) begin
        state   <= DEV_ID;
        bit_cnt <= '0;
        oe      <= 1'b0;
        busy    <= 1'b1;
      end else if (scl_rise) begin
        if (rx_state) begin
          shreg   <= nxt;
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          DEV_ID: if (last) begin
            if (nxt[7:1] != DEV_ADDR) begin
              state <= WAIT_STOP;
              busy  <= 1'b0;
            end else begin
              rw    <= nxt[RW_BIT];
              state <= DEV_ACK;
            end
          end
          ADDR_H: if (last) begin
            addr_hi <= nxt;
            state   <= ACK_H;
          end
          ADDR_L: if (last) begin
            reg_addr <= {addr_hi, nxt};
            state    <= ACK_L;
          end
          WDATA: if (last) begin
            reg_wdata <= nxt;
            reg_wr    <= 1'b1;
            state     <= WACK;
          end
          DEV_ACK: if (rw) reg_rd <= 1'b1;
          RDATA:   bit_cnt <= bit_cnt + 4'd1;
          RACK: begin
            if (sda_q == NACK) state <= WAIT_STOP;
            else               reg_rd <= 1'b1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          DEV_ACK, ACK_H, ACK_L, WACK: begin
            // first fall opens the ACK slot, second fall closes it
            if (!oe) begin
              oe <= ~ACK;
            end else begin
              oe      <= 1'b0;
              bit_cnt <= '0;
              case (state)
                DEV_ACK: begin
                  if (rw) begin
                    state <= RDATA;
                    oe    <= ~shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                  end else begin
                    state <= ADDR_H;
                  end
                end
                ACK_H:   state <= ADDR_L;
                default: state <= WDATA;
              endcase
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              oe    <= 1'b0;
              state <= RACK;
            end else begin
              oe    <= ~shreg[7];
              shreg <= {shreg[6:0], 1'b0};
            end
          end
          RACK: begin
            state   <= RDATA;
            bit_cnt <= '0;
            oe      <= ~shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
